// File: rtl/prog_rom_fetch_if.sv
// Bundle of the cache-side level request and the SDRAM-side toggle handshake
// signals that pass through the program-ROM fetch bridge.
//
// Handshake rules:
//   cache side: rom_req is a level held high until rom_valid is seen; rom_valid
//               stays high while rom_req stays high; rom_req must drop for at
//               least one clock between requests.
//   sdram side: each read is requested by toggling sdr_req; the read completes
//               when sdr_ack equals sdr_req, at which point sdr_data is valid.
interface prog_rom_fetch_if #(
    parameter int AW     = 18,
    parameter int SDR_AW = 24
);
    logic              rom_req;
    logic [AW-1:0]     rom_addr;
    logic [15:0]       rom_data;
    logic              rom_valid;
    logic              sdr_req;
    logic              sdr_ack;
    logic [SDR_AW-1:0] sdr_addr;
    logic [31:0]       sdr_data;
    logic              flush;

    // Bridge side: serves the cache, drives the SDRAM read port.
    modport slave (
        input  rom_req, rom_addr, sdr_ack, sdr_data, flush,
        output rom_data, rom_valid, sdr_req, sdr_addr
    );

    // Environment side: the cache plus the SDRAM controller.
    modport master (
        output rom_req, rom_addr, sdr_ack, sdr_data, flush,
        input  rom_data, rom_valid, sdr_req, sdr_addr
    );
endinterface

// File: rtl/prog_rom_fetch.sv
// Miss-fill bridge between the program-ROM cache and an SDRAM read port.
// Keeps the last 32-bit SDRAM line so the neighbouring 16-bit word is served
// without another SDRAM access.
module prog_rom_fetch #(
    parameter int              AW     = 18,
    parameter int              SDR_AW = 24,
    parameter logic [SDR_AW-1:0] BASE = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    prog_rom_fetch_if.slave        bus,
    output logic [1:0]             state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              sdr_req_q,    sdr_req_d;
    logic [SDR_AW-1:0] sdr_addr_q,   sdr_addr_d;
    logic [15:0]       rom_data_q,   rom_data_d;
    logic              rom_valid_q,  rom_valid_d;
    logic [31:0]       line_q,       line_d;
    logic [AW-2:0]     tag_q,        tag_d;
    logic              line_valid_q, line_valid_d;
    logic [AW-1:0]     addr_q,       addr_d;
    logic              flush_pend_q, flush_pend_d;

    logic              hit;
    logic              ack_seen;
    logic [SDR_AW-1:0] fill_addr;

    assign hit       = line_valid_q && (tag_q == bus.rom_addr[AW-1:1]);
    assign ack_seen  = (bus.sdr_ack == sdr_req_q);
    // Byte address of the 32-bit line holding the requested word; wraps silently.
    assign fill_addr = BASE + SDR_AW'({bus.rom_addr[AW-1:1], 2'b00});

    // Next-state logic for the request FSM and the line buffer.
    always_comb begin
        state_d      = state_q;
        sdr_req_d    = sdr_req_q;
        sdr_addr_d   = sdr_addr_q;
        rom_data_d   = rom_data_q;
        rom_valid_d  = rom_valid_q;
        line_d       = line_q;
        tag_d        = tag_q;
        line_valid_d = line_valid_q;
        addr_d       = addr_q;
        flush_pend_d = flush_pend_q;

        case (state_q)
            S_IDLE: begin
                if (bus.rom_req) begin
                    if (hit) begin
                        rom_data_d  = bus.rom_addr[0] ? line_q[31:16] : line_q[15:0];
                        rom_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        addr_d     = bus.rom_addr;
                        sdr_addr_d = fill_addr;
                        sdr_req_d  = ~sdr_req_q;
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (ack_seen) begin
                    line_d       = bus.sdr_data;
                    tag_d        = addr_q[AW-1:1];
                    line_valid_d = ~flush_pend_q;
                    flush_pend_d = 1'b0;
                    if (bus.rom_req) begin
                        rom_data_d  = addr_q[0] ? bus.sdr_data[31:16] : bus.sdr_data[15:0];
                        rom_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                if (!bus.rom_req) begin
                    rom_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rom_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        // A flush always wins, including over a fill landing on the same edge.
        if (bus.flush) begin
            line_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sdr_req_q    <= 1'b0;
            sdr_addr_q   <= '0;
            rom_data_q   <= '0;
            rom_valid_q  <= 1'b0;
            line_q       <= '0;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sdr_req_q    <= sdr_req_d;
            sdr_addr_q   <= sdr_addr_d;
            rom_data_q   <= rom_data_d;
            rom_valid_q  <= rom_valid_d;
            line_q       <= line_d;
            tag_q        <= tag_d;
            line_valid_q <= line_valid_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign bus.sdr_req   = sdr_req_q;
    assign bus.sdr_addr  = sdr_addr_q;
    assign bus.rom_data  = rom_data_q;
    assign bus.rom_valid = rom_valid_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_prog_rom_fetch.sv
// Directed bench for the program-ROM fetch bridge.
module tb_prog_rom_fetch;
    localparam int AW     = 18;
    localparam int SDR_AW = 24;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic       clk;
    logic       reset_n;
    logic [1:0] state;

    int n_cmp;
    int n_bad;

    prog_rom_fetch_if #(.AW(AW), .SDR_AW(SDR_AW)) bus ();

    prog_rom_fetch #(.AW(AW), .SDR_AW(SDR_AW), .BASE(24'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .state_o (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic request(input logic [AW-1:0] a);
        bus.rom_req  = 1'b1;
        bus.rom_addr = a;
    endtask

    task automatic ack(input logic lvl, input logic [31:0] d);
        bus.sdr_ack  = lvl;
        bus.sdr_data = d;
    endtask

    // Drop the request, wait one edge, and confirm the bridge is back in IDLE.
    task automatic release_req(input string tag);
        bus.rom_req = 1'b0;
        tick();
        check({tag, "_rel_valid"}, 32'(bus.rom_valid), 32'd0);
        check({tag, "_rel_state"}, 32'(state), 32'(S_IDLE));
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset_n      = 1'b0;
        bus.rom_req  = 1'b0;
        bus.rom_addr = '0;
        bus.sdr_ack  = 1'b0;
        bus.sdr_data = '0;
        bus.flush    = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_sdr_req", 32'(bus.sdr_req), 32'd0);
        check("rst_valid", 32'(bus.rom_valid), 32'd0);
        check("rst_data", 32'(bus.rom_data), 32'd0);
        check("rst_addr", 32'(bus.sdr_addr), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: miss on 0x10 then fill
        request(18'h00010);
        tick();
        check("t1_state", 32'(state), 32'(S_WAIT));
        check("t1_sdr_req", 32'(bus.sdr_req), 32'd1);
        check("t1_sdr_addr", 32'(bus.sdr_addr), 32'h000020);
        check("t1_valid_wait", 32'(bus.rom_valid), 32'd0);
        ack(1'b1, 32'hBEEF_1234);
        tick();
        check("t1_valid", 32'(bus.rom_valid), 32'd1);
        check("t1_data", 32'(bus.rom_data), 32'h1234);
        tick();
        check("t1_hold_valid", 32'(bus.rom_valid), 32'd1);
        check("t1_hold_req", 32'(bus.sdr_req), 32'd1);
        release_req("t1");

        // 2: adjacent odd word hits the line
        request(18'h00011);
        tick();
        check("t2_valid", 32'(bus.rom_valid), 32'd1);
        check("t2_data", 32'(bus.rom_data), 32'hBEEF);
        check("t2_no_toggle", 32'(bus.sdr_req), 32'd1);
        release_req("t2");

        // 3: abandoned miss still fills the line
        request(18'h00020);
        tick();
        check("t3_sdr_req", 32'(bus.sdr_req), 32'd0);
        check("t3_sdr_addr", 32'(bus.sdr_addr), 32'h000040);
        bus.rom_req = 1'b0;
        tick();
        check("t3_valid_drop", 32'(bus.rom_valid), 32'd0);
        ack(1'b0, 32'hCAFE_0001);
        tick();
        check("t3_valid_fill", 32'(bus.rom_valid), 32'd0);
        check("t3_state", 32'(state), 32'(S_IDLE));
        tick();
        check("t3_valid_idle", 32'(bus.rom_valid), 32'd0);
        request(18'h00021);
        tick();
        check("t3_hit_valid", 32'(bus.rom_valid), 32'd1);
        check("t3_hit_data", 32'(bus.rom_data), 32'hCAFE);
        check("t3_no_toggle", 32'(bus.sdr_req), 32'd0);
        release_req("t3");

        // 4: flush during WAIT keeps the arriving line invalid
        request(18'h00030);
        tick();
        check("t4_sdr_req", 32'(bus.sdr_req), 32'd1);
        check("t4_sdr_addr", 32'(bus.sdr_addr), 32'h000060);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t4_valid_flush", 32'(bus.rom_valid), 32'd0);
        ack(1'b1, 32'h1234_5678);
        tick();
        check("t4_valid", 32'(bus.rom_valid), 32'd1);
        check("t4_data", 32'(bus.rom_data), 32'h5678);
        release_req("t4");
        request(18'h00030);
        tick();
        check("t4_remiss_state", 32'(state), 32'(S_WAIT));
        check("t4_remiss_req", 32'(bus.sdr_req), 32'd0);
        ack(1'b0, 32'h1234_5678);
        tick();
        check("t4_refill_data", 32'(bus.rom_data), 32'h5678);
        release_req("t4b");

        // 5: slow ack, outputs hold
        request(18'h00040);
        tick();
        check("t5_sdr_req", 32'(bus.sdr_req), 32'd1);
        check("t5_sdr_addr", 32'(bus.sdr_addr), 32'h000080);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_wait_valid", 32'(bus.rom_valid), 32'd0);
            check("t5_wait_req", 32'(bus.sdr_req), 32'd1);
            check("t5_wait_addr", 32'(bus.sdr_addr), 32'h000080);
        end
        ack(1'b1, 32'hAAAA_5555);
        tick();
        check("t5_valid", 32'(bus.rom_valid), 32'd1);
        check("t5_data", 32'(bus.rom_data), 32'h5555);
        release_req("t5");

        // 6: reset in the middle of a miss
        request(18'h00060);
        tick();
        check("t6_pre_req", 32'(bus.sdr_req), 32'd0);
        ack(1'b0, 32'h7777_6666);
        tick();
        check("t6_pre_data", 32'(bus.rom_data), 32'h6666);
        release_req("t6a");
        request(18'h00050);
        tick();
        check("t6_wait_state", 32'(state), 32'(S_WAIT));
        check("t6_wait_req", 32'(bus.sdr_req), 32'd1);
        check("t6_wait_addr", 32'(bus.sdr_addr), 32'h0000A0);
        reset_n     = 1'b0;
        bus.rom_req = 1'b0;
        ack(1'b0, 32'h0);
        tick();
        check("t6_rst_req", 32'(bus.sdr_req), 32'd0);
        check("t6_rst_valid", 32'(bus.rom_valid), 32'd0);
        check("t6_rst_state", 32'(state), 32'(S_IDLE));
        reset_n = 1'b1;
        tick();
        request(18'h00061);
        tick();
        check("t6_line_cleared", 32'(state), 32'(S_WAIT));
        check("t6_after_req", 32'(bus.sdr_req), 32'd1);
        check("t6_after_valid", 32'(bus.rom_valid), 32'd0);
        ack(1'b1, 32'h9999_8888);
        tick();
        check("t6_after_data", 32'(bus.rom_data), 32'h9999);
        release_req("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
